comma_sync_ctrl: RTL

//  Word-alignment/synchronisation controller for the 1000BASE-X receive path.

---
 rtl/comma_sync_pkg.sv | 22 ++
 rtl/comma_sync_ctrl_err_monitor.sv | 85 ++++++++
 rtl/comma_sync_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/comma_sync_pkg.sv
// rtl/comma_sync_pkg.sv - shared state type and constants for the comma sync controller
package comma_sync_pkg;

   typedef enum logic [1:0] {
      LOS  = 2'd0,
      SLIP = 2'd1,
      ACQ  = 2'd2,
      SYNC = 2'd3
   } sync_state_t;

   // K28.5 in both running disparities (abcdei fghj order)
   localparam logic [9:0] K28_5_POS = 10'b0011111010;
   localparam logic [9:0] K28_5_NEG = 10'b1100000101;

   // A 10-bit word only has bit positions 0..9
   localparam logic [3:0] MAX_OFFSET = 4'd9;

   function automatic logic offset_legal(input logic [3:0] off);
      return off <= MAX_OFFSET;
   endfunction

endpackage

// File: rtl/comma_sync_ctrl_err_monitor.sv
// rtl/comma_sync_ctrl_err_monitor.sv - error/clean-run/comma-timeout bookkeeping while in sync
module comma_err_monitor #(
   parameter int ERR_MAX   = 4,
   parameter int GOOD_RUN  = 4,
   parameter int COMMA_TMO = 1024
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_enable,
   input  logic       i_clear,
   input  logic       i_valid,
   input  logic       i_err_word,
   input  logic       i_aligned,
   output logic       o_drop,
   output logic [2:0] o_err_level
);

   localparam int ERR_W  = $clog2(ERR_MAX) + 1;
   localparam int GOOD_W = $clog2(GOOD_RUN) + 1;
   localparam int TMO_W  = $clog2(COMMA_TMO) + 1;

   logic [ERR_W-1:0]  r_err_cnt,  w_err_next;
   logic [GOOD_W-1:0] r_good_cnt, w_good_next;
   logic [TMO_W-1:0]  r_tmo_cnt,  w_tmo_next;

   logic w_event;
   logic w_err_inc;
   logic w_clean;
   logic w_good_wrap;

   assign w_event     = i_enable & i_valid;
   assign w_err_inc   = w_event & i_err_word;
   assign w_clean     = w_event & ~i_err_word;
   assign w_good_wrap = w_clean && (int'(r_good_cnt) == GOOD_RUN - 1);

   // Next counter values for the current word; an error outranks a coincident aligned comma
   always_comb begin
      w_err_next  = r_err_cnt;
      w_good_next = r_good_cnt;
      w_tmo_next  = r_tmo_cnt;
      if (w_err_inc) begin
         if (r_err_cnt != '1) begin
            w_err_next = r_err_cnt + 1'b1;
         end
         w_good_next = '0;
      end else if (w_clean) begin
         if (w_good_wrap) begin
            w_good_next = '0;
            if (r_err_cnt != '0) begin
               w_err_next = r_err_cnt - 1'b1;
            end
         end else begin
            w_good_next = r_good_cnt + 1'b1;
         end
      end
      if (w_event) begin
         w_tmo_next = i_aligned ? '0 : r_tmo_cnt + 1'b1;
      end
   end

   // Drop is raised in the same cycle as the offending word so the FSM leaves SYNC on that edge
   always_comb begin
      o_drop = w_event &&
               ((int'(w_err_next) >= ERR_MAX) || (int'(w_tmo_next) >= COMMA_TMO));
   end

   // Status view of the error count, saturated to the 3-bit port
   always_comb begin
      o_err_level = (int'(r_err_cnt) > 7) ? 3'd7 : 3'(r_err_cnt);
   end

   // Counters; cleared whenever the link is not in SYNC
   always_ff @(posedge clk) begin
      if (reset || i_clear) begin
         r_err_cnt  <= '0;
         r_good_cnt <= '0;
         r_tmo_cnt  <= '0;
      end else begin
         r_err_cnt  <= w_err_next;
         r_good_cnt <= w_good_next;
         r_tmo_cnt  <= w_tmo_next;
      end
   end

endmodule

// File: rtl/comma_sync_ctrl.sv
// rtl/comma_sync_ctrl.sv - word alignment FSM with paced SERDES bitslip and sync supervision
module comma_sync_ctrl
   import comma_sync_pkg::*;
#(
   parameter int SLIP_SETTLE = 4,
   parameter int LOCK_COMMAS = 3,
   parameter int ERR_MAX     = 4,
   parameter int GOOD_RUN    = 4,
   parameter int COMMA_TMO   = 1024
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_word_valid,
   input  logic       i_comma,
   input  logic [3:0] i_offset,
   input  logic       i_code_err,
   output logic       o_bitslip,
   output logic       o_aligning,
   output logic       o_sync_ok,
   output logic [2:0] o_err_level
);

   localparam int CNT_W = $clog2(LOCK_COMMAS) + 1;
   localparam int SET_W = $clog2(SLIP_SETTLE) + 1;

   sync_state_t      r_state, w_next_state;
   logic [CNT_W-1:0] r_comma_cnt, w_next_comma_cnt;
   logic [3:0]       r_slip_rem, w_next_slip_rem;
   logic [SET_W-1:0] r_settle, w_next_settle;
   logic             r_bitslip, w_next_bitslip;
   logic             r_aligning;
   logic             r_sync_ok;

   logic w_comma_ok;
   logic w_aligned;
   logic w_misaligned;
   logic w_err_word;
   logic w_drop;

   // An out-of-range offset is aligner garbage and counts as "no comma"
   assign w_comma_ok   = i_word_valid & i_comma & offset_legal(i_offset);
   assign w_aligned    = w_comma_ok & (i_offset == 4'd0);
   assign w_misaligned = w_comma_ok & (i_offset != 4'd0);
   assign w_err_word   = i_code_err | w_misaligned;

   comma_err_monitor #(
      .ERR_MAX   (ERR_MAX),
      .GOOD_RUN  (GOOD_RUN),
      .COMMA_TMO (COMMA_TMO)
   ) u_err_monitor (
      .clk         (clk),
      .reset       (reset),
      .i_enable    (r_state == SYNC),
      .i_clear     (r_state != SYNC),
      .i_valid     (i_word_valid),
      .i_err_word  (w_err_word),
      .i_aligned   (w_aligned),
      .o_drop      (w_drop),
      .o_err_level (o_err_level)
   );

   // Next-state, comma counting and slip pacing; each slip is one pulse plus SLIP_SETTLE idle cycles
   always_comb begin
      w_next_state     = r_state;
      w_next_comma_cnt = r_comma_cnt;
      w_next_slip_rem  = r_slip_rem;
      w_next_settle    = r_settle;
      w_next_bitslip   = 1'b0;
      case (r_state)
         LOS: begin
            // code_err is meaningless before alignment, so only comma position matters here
            if (w_aligned) begin
               w_next_comma_cnt = CNT_W'(1);
               w_next_state     = (LOCK_COMMAS <= 1) ? SYNC : ACQ;
            end else if (w_misaligned) begin
               w_next_state    = SLIP;
               w_next_slip_rem = i_offset - 4'd1;
               w_next_settle   = SET_W'(SLIP_SETTLE);
               w_next_bitslip  = 1'b1;
            end
         end
         SLIP: begin
            if (r_settle != '0) begin
               w_next_settle = r_settle - 1'b1;
            end else if (r_slip_rem != '0) begin
               w_next_slip_rem = r_slip_rem - 4'd1;
               w_next_settle   = SET_W'(SLIP_SETTLE);
               w_next_bitslip  = 1'b1;
            end else begin
               // Go back and re-check the comma position rather than assume the slips landed
               w_next_state = LOS;
            end
         end
         ACQ: begin
            if (i_word_valid) begin
               if (i_code_err || w_misaligned) begin
                  w_next_state     = LOS;
                  w_next_comma_cnt = '0;
               end else if (w_aligned) begin
                  if (int'(r_comma_cnt) + 1 >= LOCK_COMMAS) begin
                     w_next_state     = SYNC;
                     w_next_comma_cnt = '0;
                  end else begin
                     w_next_comma_cnt = r_comma_cnt + 1'b1;
                  end
               end
            end
         end
         SYNC: begin
            if (w_drop) begin
               w_next_state = LOS;
            end
         end
         default: begin
            w_next_state = LOS;
         end
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= LOS;
         r_comma_cnt <= '0;
         r_slip_rem  <= '0;
         r_settle    <= '0;
         r_bitslip   <= 1'b0;
         r_aligning  <= 1'b0;
         r_sync_ok   <= 1'b0;
      end else begin
         r_state     <= w_next_state;
         r_comma_cnt <= w_next_comma_cnt;
         r_slip_rem  <= w_next_slip_rem;
         r_settle    <= w_next_settle;
         r_bitslip   <= w_next_bitslip;
         r_aligning  <= (w_next_state == SLIP);
         r_sync_ok   <= (w_next_state == SYNC);
      end
   end

   assign o_bitslip  = r_bitslip;
   assign o_aligning = r_aligning;
   assign o_sync_ok  = r_sync_ok;

endmodule
